pwm_generator: RTL



---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_sample_fifo.sv | 85 ++++++++
 rtl/pwm_generator.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM audio path.
package pwm_pkg;

    localparam int SAMPLE_W = 16;
    localparam int PWM_BITS = 8;

    // Silence: a zero signed sample sits at the middle of the carrier range.
    localparam logic [SAMPLE_W-1:0] MIDSCALE   = 16'h0000;
    localparam logic [PWM_BITS-1:0] DUTY_RESET = 8'h80;

    // Signed sample to unsigned duty: flipping the sign bit turns two's
    // complement into offset binary; the top PWM_BITS of that become the duty.
    function automatic logic [PWM_BITS-1:0] sample_to_duty(input logic [SAMPLE_W-1:0] s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: PWM_BITS-1]};
    endfunction

endpackage

// File: rtl/pwm_sample_fifo.sv
// Small sample buffer between the upstream loader and the sample timer.
// Flags are decoded from a registered occupancy count, so the ready signal
// seen upstream never depends combinationally on the write request.
module pwm_sample_fifo
    import pwm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = SAMPLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // The buffer is only a few entries deep, so the head is read straight
    // from the register array; a pop takes effect in the same edge it is used.
    assign rd_data = mem[rd_ptr_reg];

    // Pointer and occupancy next-state; simultaneous push and pop keep the count.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and occupancy registers; reset discards everything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// PWM audio player: buffers signed samples, releases one per sample period
// and renders it as an 8-bit pulse width on a free-running carrier.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int SAMPLE_DIV = 3125,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sound,
    input  logic                sound_valid,
    output logic                sound_rdy,
    output logic                pwm_out,
    output logic                underrun
);

    localparam logic [15:0]         DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [15:0]         DIV_ONE  = 16'd1;
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

    logic [15:0]         div_cnt_reg;
    logic [15:0]         div_cnt_next;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [PWM_BITS-1:0] pwm_cnt_next;
    logic [SAMPLE_W-1:0] cur_sample_reg;
    logic [SAMPLE_W-1:0] cur_sample_next;
    logic [PWM_BITS-1:0] duty_reg;
    logic [PWM_BITS-1:0] duty_next;
    logic                pwm_out_reg;
    logic                pwm_out_next;
    logic                underrun_reg;
    logic                underrun_next;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;

    // Ready comes only from the registered occupancy, never from sound_valid.
    assign sound_rdy = ~fifo_full;
    assign fifo_push = sound_valid & sound_rdy;

    // A tick on an empty buffer is an underrun even if a push lands on the
    // same edge: that sample waits for the next tick rather than bypassing.
    assign tick      = enable & (div_cnt_reg == DIV_LAST);
    assign fifo_pop  = tick & ~fifo_empty;

    pwm_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (sound),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sample timer next-state: counts 0..SAMPLE_DIV-1 while enabled, parked at 0 otherwise.
    always_comb begin
        div_cnt_next = '0;
        if (enable) begin
            div_cnt_next = tick ? '0 : div_cnt_reg + DIV_ONE;
        end
    end

    // Sample timer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    // Sample fetch next-state: take the buffer head on a tick, or fall back to silence.
    always_comb begin
        cur_sample_next = cur_sample_reg;
        underrun_next   = 1'b0;
        if (tick) begin
            if (!fifo_empty) begin
                cur_sample_next = fifo_head;
            end else begin
                cur_sample_next = MIDSCALE;
                underrun_next   = 1'b1;
            end
        end
    end

    // Current sample and underrun pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_sample_reg <= MIDSCALE;
            underrun_reg   <= 1'b0;
        end else begin
            cur_sample_reg <= cur_sample_next;
            underrun_reg   <= underrun_next;
        end
    end

    // Carrier and comparator next-state; duty only reloads at the period end
    // so a pulse is never cut short or stretched mid-period.
    always_comb begin
        pwm_cnt_next = '0;
        duty_next    = duty_reg;
        pwm_out_next = 1'b0;
        if (enable) begin
            pwm_cnt_next = pwm_cnt_reg + PWM_ONE;
            pwm_out_next = (pwm_cnt_reg < duty_reg);
            if (pwm_cnt_reg == '1) begin
                duty_next = sample_to_duty(cur_sample_reg);
            end
        end
    end

    // Carrier counter, duty and registered PWM output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_reg <= '0;
            duty_reg    <= DUTY_RESET;
            pwm_out_reg <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_next;
            duty_reg    <= duty_next;
            pwm_out_reg <= pwm_out_next;
        end
    end

    assign pwm_out  = pwm_out_reg;
    assign underrun = underrun_reg;

endmodule
